// File: rtl/booth_multiplicador.sv
// Sequential signed NxN radix-2 Booth multiplier: loads A/B after reset release,
// runs one Booth step per clock and holds the registered product until the next reset.
module booth_multiplicador #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     A,
  input  logic [N-1:0]     B,
  output logic [2*N-1:0]   c,
  output logic             neg
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {LOAD, RUN, DONE} state_t;

  state_t           state_q;
  logic [N:0]       m_q;
  logic [N:0]       acc_q, acc_d, sum;
  logic [N-1:0]     q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [CW-1:0]    cnt_q;
  logic [2*N-1:0]   c_q;
  logic             neg_q;

  // One Booth step: conditional add/subtract of M, then arithmetic shift of {acc,Q,Q-1}.
  always_comb begin
    sum = acc_q;
    case ({q_q[0], qm1_q})
      2'b01:   sum = acc_q + m_q;
      2'b10:   sum = acc_q - m_q;
      default: sum = acc_q;
    endcase
    acc_d = {sum[N], sum[N:1]};
    q_d   = {sum[0], q_q[N-1:1]};
    qm1_d = q_q[0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      c_q     <= '0;
      neg_q   <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          m_q     <= {A[N-1], A};
          q_q     <= B;
          acc_q   <= '0;
          qm1_q   <= 1'b0;
          cnt_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          acc_q <= acc_d;
          q_q   <= q_d;
          qm1_q <= qm1_d;
          cnt_q <= cnt_q + 1'b1;
          // Product is captured from the final step's next-state so it is valid on the same edge.
          if (cnt_q == CW'(N - 1)) begin
            state_q <= DONE;
            c_q     <= {acc_d[N-1:0], q_d};
            neg_q   <= acc_d[N-1];
          end
        end
        DONE: state_q <= DONE;
        default: state_q <= LOAD;
      endcase
    end
  end

  assign c   = c_q;
  assign neg = neg_q;

endmodule

// File: tb/tb_booth_multiplicador.sv
// Self-checking bench for booth_multiplicador: directed corners plus random operands
// compared against plain signed multiplication.
module tb_booth_multiplicador;

  logic        clk;
  logic        rst;
  logic [7:0]  A, B;
  logic [15:0] c;
  logic        neg;

  int tests = 0;
  int fails = 0;

  booth_multiplicador #(.N(8)) dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .B   (B),
    .c   (c),
    .neg (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_prod(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[15:0];
  endfunction

  function automatic logic model_neg(input logic [7:0] a, input logic [7:0] b);
    return (int'($signed(a)) * int'($signed(b))) < 0;
  endfunction

  // Reset, release with a/b, check c==0 for 8 edges and the result after the 9th.
  // With change set, operands are overwritten after the 2nd edge and must be ignored.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input bit change);
    @(negedge clk);
    rst = 1'b0;
    A = a;
    B = b;
    #1;
    chk({tag, "_rst_c"}, c, 16'h0000);
    chk({tag, "_rst_neg"}, {15'd0, neg}, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("%s_busy%0d", tag, i), c, 16'h0000);
      if (change && i == 2) begin
        A = 8'd100;
        B = 8'(-100);
      end
    end
    @(posedge clk);
    #1;
    chk({tag, "_c"}, c, model_prod(a, b));
    chk({tag, "_neg"}, {15'd0, neg}, {15'd0, model_neg(a, b)});
  endtask

  initial begin
    rst = 1'b0;
    A   = '0;
    B   = '0;
    #12;
    chk("por_c", c, 16'h0000);
    chk("por_neg", {15'd0, neg}, 16'h0000);

    run_op("t2xm4", 8'd2, 8'(-4), 1'b0);
    chk("t2xm4_lit", c, 16'hFFF8);
    run_op("t9xm3", 8'd9, 8'(-3), 1'b0);
    chk("t9xm3_lit", c, 16'hFFE5);
    run_op("tm9x3", 8'(-9), 8'd3, 1'b0);
    chk("tm9x3_lit", c, 16'hFFE5);
    run_op("tm128xm128", 8'h80, 8'h80, 1'b0);
    chk("tm128xm128_lit", c, 16'h4000);
    run_op("t127x127", 8'd127, 8'd127, 1'b0);
    chk("t127x127_lit", c, 16'h3F01);
    run_op("tm128x127", 8'h80, 8'd127, 1'b0);
    chk("tm128x127_lit", c, 16'hC080);
    chk("tm128x127_neglit", {15'd0, neg}, 16'h0001);
    run_op("t0xm5", 8'd0, 8'(-5), 1'b0);
    chk("t0xm5_neglit", {15'd0, neg}, 16'h0000);
    run_op("tm1xm1", 8'hFF, 8'hFF, 1'b0);
    chk("tm1xm1_lit", c, 16'h0001);

    run_op("tchg", 8'd5, 8'd6, 1'b1);
    chk("tchg_lit", c, 16'h001E);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d_c", i), c, 16'h001E);
      chk($sformatf("hold%0d_neg", i), {15'd0, neg}, 16'h0000);
    end

    // Abort mid-run, then restart with new operands.
    @(negedge clk);
    rst = 1'b0;
    A = 8'd7;
    B = 8'd7;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_run_c", c, 16'h0000);
    chk("abort_run_neg", {15'd0, neg}, 16'h0000);
    run_op("tm3x4", 8'(-3), 8'd4, 1'b0);
    chk("tm3x4_lit", c, 16'hFFF4);

    // Reset after completion clears outputs asynchronously, between clock edges.
    #2;
    rst = 1'b0;
    #1;
    chk("abort_done_c", c, 16'h0000);
    chk("abort_done_neg", {15'd0, neg}, 16'h0000);

    for (int k = 0; k < 30; k++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_op($sformatf("rnd%0d", k), ra, rb, k[0]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/booth_multiplicador.md
Name: booth_multiplicador

Overview:
- Sequential signed 8x8 multiplier using radix-2 Booth recoding.
- Ships as the multiply unit of the ALU.
- Samples A and B once after reset is released, then iterates one Booth step per clock.
- Presents the 16-bit two's-complement product on c and its sign on neg, and holds them until the next reset.
- There is no start pulse: each reset release begins a new operation.

Parameters:
- N, 8, operand width. Product width is 2N. Iteration counter width is clog2(N)+1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset. rst=0 clears all state; operation begins after rst returns to 1.
- A    input  8  multiplicand, signed two's complement.
- B    input  8  multiplier, signed two's complement.
- c    output 16 signed product A*B; 0 until the operation completes.
- neg  output 1  1 when the completed product is negative (equals c[15]); 0 otherwise.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=LOAD, counter=0, accumulator=0, Q=0, Q-1=0.
  - c=16'h0000, neg=0.
  - Reset asserted mid-operation aborts immediately, and outputs return to 0.
- FSM states: LOAD -> RUN -> DONE.
  - LOAD (first rising edge with rst=1):
    - M <= sign-extend(A) to 9 bits.
    - Q <= B, accumulator (9 bits) <= 0, Q-1 <= 0, counter <= 0.
    - Go to RUN.
  - RUN, one Booth step per edge:
    - {Q0,Q-1}=01: acc <= acc+M.
    - {Q0,Q-1}=10: acc <= acc-M.
    - 00 or 11: no add.
    - Then arithmetic-shift {acc,Q,Q-1} right by 1, replicating the acc sign bit.
    - counter++. After the 8th step, go to DONE.
  - DONE:
    - On entry, c <= {acc[7:0],Q} and neg <= product sign.
    - Stays in DONE, holding c and neg, until the next reset.
- Latency: c and neg are valid after the 9th rising edge following reset release (1 load + 8 steps).
  - c is 0 during LOAD and RUN.
- Operands are sampled only in LOAD. Changes on A and B afterwards are ignored until the next reset.
- Arithmetic:
  - The accumulator is 9 bits so that subtracting M=-128 does not overflow.
  - The result is exact for the full range -128..127 x -128..127.
  - Extremes: -128*-128=+16384 (16'h4000); -128*127=-16256 (16'hC080).
- neg=0 for a zero product (including any operand 0).
- All outputs are registered; there are no combinational paths from A or B to c.

Test Plan:
- rst pulse low, release; A=2, B=-4; wait 10 cycles -> c=16'hFFF8 (-8), neg=1. c=0 throughout the first 8 cycles after release.
- Reset, then A=9, B=-3 -> c=16'hFFE5 (-27), neg=1. Then reset, A=-9, B=3 -> c=16'hFFE5, neg=1.
- Corner operands, one reset per case:
  - A=-128, B=-128 -> c=16'h4000, neg=0.
  - A=127, B=127 -> c=16'h3F01, neg=0.
  - A=-128, B=127 -> c=16'hC080, neg=1.
- A=0, B=-5 -> c=0, neg=0. A=-1, B=-1 -> c=16'h0001, neg=0.
- Release reset with A=5, B=6; change A=100 and B=-100 two cycles later -> c=16'h001E (30), neg=0. Result holds for 20 more cycles.
- Start A=7, B=7; assert rst low at cycle 4 -> c and neg drop to 0 asynchronously. Release with A=-3, B=4 -> c=16'hFFF4, neg=1 exactly 9 edges after release.
